// File: rtl/bram18_port_model_if.sv
// One BRAM18 access port: bit-granular address, write data, enables
// and registered read data.
interface bram18_port_model_if;
  logic [13:0] addr;
  logic [17:0] wdata;
  logic        ren;
  logic        wen;
  logic [1:0]  be;
  logic [17:0] rdata;
  logic        rvalid;

  modport master (
    output addr, wdata, ren, wen, be,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, wdata, ren, wen, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/bram18_port_model.sv
// Behavioural dual-port 1024x18 block RAM with per-port width modes,
// read-first semantics and write-write collision flag.
module bram18_port_model #(
  parameter logic [18431:0] INIT   = '0,
  parameter logic [2:0]     MODE_A = 3'b010,
  parameter logic [2:0]     MODE_B = 3'b010
) (
  input  logic CLK_i,
  input  logic RST_i,
  bram18_port_model_if.slave a_if,
  bram18_port_model_if.slave b_if,
  output logic COLL_o
);

  typedef enum logic [2:0] {
    W18 = 3'b010,
    W9  = 3'b001,
    W4  = 3'b100,
    W2  = 3'b110,
    W1  = 3'b101
  } wmode_e;

  function automatic wmode_e norm(input logic [2:0] m);
    unique case (m)
      3'b001:  norm = W9;
      3'b100:  norm = W4;
      3'b110:  norm = W2;
      3'b101:  norm = W1;
      default: norm = W18;
    endcase
  endfunction

  function automatic logic [4:0] offs(
    input wmode_e m,
    input logic [3:0] a
  );
    unique case (m)
      W4:      offs = {1'b0, a[3:2], 2'b00};
      W2:      offs = {1'b0, a[3:1], 1'b0};
      W1:      offs = {1'b0, a[3:0]};
      default: offs = 5'd0;
    endcase
  endfunction

  function automatic logic [17:0] wmask(
    input wmode_e m,
    input logic [3:0] a,
    input logic [1:0] be
  );
    logic [4:0] o;
    o = offs(m, a);
    unique case (m)
      W9:      wmask = a[3] ? 18'h2_FF00 : 18'h1_00FF;
      W4:      wmask = 18'h0_000F << o;
      W2:      wmask = 18'h0_0003 << o;
      W1:      wmask = 18'h0_0001 << o;
      default: wmask = {be[1], be[0],
                        {8{be[1]}}, {8{be[0]}}};
    endcase
  endfunction

  function automatic logic [17:0] wlane(
    input wmode_e m,
    input logic [3:0] a,
    input logic [17:0] wd
  );
    logic [4:0] o;
    o = offs(m, a);
    unique case (m)
      W9: wlane = a[3] ?
        {wd[16], 1'b0, wd[7:0], 8'h00} :
        {1'b0, wd[16], 8'h00, wd[7:0]};
      W4:      wlane = {14'b0, wd[3:0]} << o;
      W2:      wlane = {16'b0, wd[1:0]} << o;
      W1:      wlane = {17'b0, wd[0]} << o;
      default: wlane = wd;
    endcase
  endfunction

  function automatic logic [17:0] rlane(
    input wmode_e m,
    input logic [3:0] a,
    input logic [17:0] w
  );
    logic [15:0] t;
    t = w[15:0] >> offs(m, a);
    unique case (m)
      W9: rlane = a[3] ?
        {1'b0, w[17], 8'h00, w[15:8]} :
        {1'b0, w[16], 8'h00, w[7:0]};
      W4:      rlane = {14'b0, t[3:0]};
      W2:      rlane = {16'b0, t[1:0]};
      W1:      rlane = {17'b0, t[0]};
      default: rlane = w;
    endcase
  endfunction

  localparam wmode_e MA = norm(MODE_A);
  localparam wmode_e MB = norm(MODE_B);

  // Flat storage so INIT maps bit-for-bit onto the array
  logic [18431:0] mem_q = INIT;

  logic [17:0] rdata_a_q, rdata_b_q;
  logic        rvalid_a_q, rvalid_b_q;
  logic        coll_q;

  logic [9:0]  wa, wb;
  logic [14:0] base_a, base_b;
  logic [17:0] old_a, old_b;
  logic [17:0] ma, mb, da, db;
  logic [17:0] new_a, new_b;
  logic        same_w, coll_d;

  always_comb begin
    wa     = a_if.addr[13:4];
    wb     = b_if.addr[13:4];
    base_a = {5'b0, wa} * 15'd18;
    base_b = {5'b0, wb} * 15'd18;
    old_a  = mem_q[base_a +: 18];
    old_b  = mem_q[base_b +: 18];
    ma     = wmask(MA, a_if.addr[3:0], a_if.be);
    mb     = wmask(MB, b_if.addr[3:0], b_if.be);
    da     = wlane(MA, a_if.addr[3:0], a_if.wdata);
    db     = wlane(MB, b_if.addr[3:0], b_if.wdata);
    same_w = (wa == wb);
    new_a  = (old_a & ~ma) | (da & ma);
    // B merges over A's result so non-overlapping A bits survive
    new_b  = ((same_w && a_if.wen) ? new_a : old_b);
    new_b  = (new_b & ~mb) | (db & mb);
    coll_d = a_if.wen & b_if.wen & same_w & (|(ma & mb));
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      rvalid_a_q <= a_if.ren;
      rvalid_b_q <= b_if.ren;
      coll_q     <= coll_d;
      if (a_if.ren)
        rdata_a_q <= rlane(MA, a_if.addr[3:0], old_a);
      if (b_if.ren)
        rdata_b_q <= rlane(MB, b_if.addr[3:0], old_b);
      if (a_if.wen)
        mem_q[base_a +: 18] <= new_a;
      if (b_if.wen)
        mem_q[base_b +: 18] <= new_b;
    end
  end

  assign a_if.rdata  = rdata_a_q;
  assign a_if.rvalid = rvalid_a_q;
  assign b_if.rdata  = rdata_b_q;
  assign b_if.rvalid = rvalid_b_q;
  assign COLL_o      = coll_q;

endmodule

// File: tb/tb_bram18_port_model.sv
// Directed bench for bram18_port_model across several width pairings.
module tb_bram18_port_model;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bram18_port_model_if ia0(), ib0();
  bram18_port_model_if ia1(), ib1();
  bram18_port_model_if ia2(), ib2();
  bram18_port_model_if ia3(), ib3();
  logic coll0, coll1, coll2, coll3;

  bram18_port_model #(.MODE_A(3'b010), .MODE_B(3'b010)) u0 (
    .CLK_i(clk), .RST_i(rst), .a_if(ia0), .b_if(ib0), .COLL_o(coll0));
  bram18_port_model #(.MODE_A(3'b010), .MODE_B(3'b001)) u1 (
    .CLK_i(clk), .RST_i(rst), .a_if(ia1), .b_if(ib1), .COLL_o(coll1));
  bram18_port_model #(.MODE_A(3'b010), .MODE_B(3'b101)) u2 (
    .CLK_i(clk), .RST_i(rst), .a_if(ia2), .b_if(ib2), .COLL_o(coll2));
  bram18_port_model #(.INIT(18432'h3_1234),
    .MODE_A(3'b100), .MODE_B(3'b110)) u3 (
    .CLK_i(clk), .RST_i(rst), .a_if(ia3), .b_if(ib3), .COLL_o(coll3));

  task automatic chk(input string tag,
                     input logic [17:0] obs,
                     input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ia0.addr = '0; ia0.wdata = '0; ia0.ren = 0; ia0.wen = 0; ia0.be = 0;
    ib0.addr = '0; ib0.wdata = '0; ib0.ren = 0; ib0.wen = 0; ib0.be = 0;
    ia1.addr = '0; ia1.wdata = '0; ia1.ren = 0; ia1.wen = 0; ia1.be = 0;
    ib1.addr = '0; ib1.wdata = '0; ib1.ren = 0; ib1.wen = 0; ib1.be = 0;
    ia2.addr = '0; ia2.wdata = '0; ia2.ren = 0; ia2.wen = 0; ia2.be = 0;
    ib2.addr = '0; ib2.wdata = '0; ib2.ren = 0; ib2.wen = 0; ib2.be = 0;
    ia3.addr = '0; ia3.wdata = '0; ia3.ren = 0; ia3.wen = 0; ia3.be = 0;
    ib3.addr = '0; ib3.wdata = '0; ib3.ren = 0; ib3.wen = 0; ib3.be = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ia0.ren = 1;
    step();
    step();
    chk("rst_rdata_a", ia0.rdata, 18'h0);
    chk("rst_rvalid_a", {17'b0, ia0.rvalid}, 18'h0);
    chk("rst_rvalid_b", {17'b0, ib0.rvalid}, 18'h0);
    chk("rst_coll", {17'b0, coll0}, 18'h0);

    // x18 byte enable write then read
    rst = 1'b0;
    idle();
    ia0.wen = 1; ia0.addr = 14'h0050;
    ia0.wdata = 18'h3_ABCD; ia0.be = 2'b01;
    step();
    idle();
    ia0.ren = 1; ia0.addr = 14'h0050;
    step();
    chk("be_rvalid", {17'b0, ia0.rvalid}, 18'h1);
    chk("be_rdata", ia0.rdata, 18'h1_00CD);
    idle();
    step();
    chk("idle_rvalid", {17'b0, ia0.rvalid}, 18'h0);
    chk("idle_hold", ia0.rdata, 18'h1_00CD);

    // overlapping write-write collision
    ia0.wen = 1; ia0.addr = 14'h0070;
    ia0.wdata = 18'h0_1111; ia0.be = 2'b11;
    ib0.wen = 1; ib0.addr = 14'h0070;
    ib0.wdata = 18'h0_2222; ib0.be = 2'b11;
    step();
    chk("coll_pulse", {17'b0, coll0}, 18'h1);
    idle();
    ia0.ren = 1; ia0.addr = 14'h0070;
    step();
    chk("coll_clear", {17'b0, coll0}, 18'h0);
    chk("coll_data", ia0.rdata, 18'h0_2222);

    // disjoint bytes of one word: both land, no collision
    idle();
    ia0.wen = 1; ia0.addr = 14'h0080;
    ia0.wdata = 18'h0_00AA; ia0.be = 2'b01;
    ib0.wen = 1; ib0.addr = 14'h0080;
    ib0.wdata = 18'h0_BB00; ib0.be = 2'b10;
    step();
    chk("nocoll", {17'b0, coll0}, 18'h0);
    idle();
    ib0.ren = 1; ib0.addr = 14'h0080;
    step();
    chk("merge_data", ib0.rdata, 18'h0_BBAA);

    // read-first on the same port
    idle();
    ia0.wen = 1; ia0.addr = 14'h0030;
    ia0.wdata = 18'h0_0042; ia0.be = 2'b11;
    step();
    ia0.ren = 1; ia0.wdata = 18'h0_0099;
    step();
    chk("rf_old", ia0.rdata, 18'h0_0042);
    idle();
    ia0.ren = 1; ia0.addr = 14'h0030;
    step();
    chk("rf_new", ia0.rdata, 18'h0_0099);

    // cross-port: B reads while A writes the same word
    idle();
    ia0.wen = 1; ia0.addr = 14'h0030;
    ia0.wdata = 18'h0_0123; ia0.be = 2'b11;
    ib0.ren = 1; ib0.addr = 14'h0030;
    step();
    chk("xport_old", ib0.rdata, 18'h0_0099);

    // reset mid-operation
    idle();
    rst = 1'b1;
    ia0.ren = 1; ia0.addr = 14'h0030;
    ib0.wen = 1; ib0.addr = 14'h0030;
    ib0.wdata = 18'h3_FFFF; ib0.be = 2'b11;
    step();
    chk("rstmid_rdata_a", ia0.rdata, 18'h0);
    chk("rstmid_rdata_b", ib0.rdata, 18'h0);
    chk("rstmid_rvalid", {17'b0, ia0.rvalid}, 18'h0);
    chk("rstmid_coll", {17'b0, coll0}, 18'h0);
    rst = 1'b0;
    idle();
    ia0.ren = 1; ia0.addr = 14'h0030;
    step();
    chk("post_rst_rvalid", {17'b0, ia0.rvalid}, 18'h1);
    chk("post_rst_mem", ia0.rdata, 18'h0_0123);

    // mixed width: B x9 writes byte1 of word 5
    idle();
    ib1.wen = 1; ib1.addr = 14'h0058; ib1.wdata = 18'h1_005A;
    step();
    idle();
    ia1.ren = 1; ia1.addr = 14'h0050;
    ib1.ren = 1; ib1.addr = 14'h0058;
    step();
    chk("x9_word", ia1.rdata, 18'h2_5A00);
    chk("x9_byte", ib1.rdata, 18'h1_005A);

    // x1 path
    idle();
    ib2.wen = 1; ib2.addr = 14'h0023; ib2.wdata = 18'h0_0001;
    step();
    idle();
    ib2.ren = 1; ib2.addr = 14'h0023;
    ia2.ren = 1; ia2.addr = 14'h0020;
    step();
    chk("x1_bit", ib2.rdata, 18'h0_0001);
    chk("x1_word", ia2.rdata, 18'h0_0008);
    idle();
    ib2.ren = 1; ib2.addr = 14'h0022;
    step();
    chk("x1_neighbor", ib2.rdata, 18'h0);

    // INIT contents survive reset; x4 / x2 fields
    idle();
    ia3.ren = 1; ia3.addr = 14'h0004;
    ib3.ren = 1; ib3.addr = 14'h0002;
    step();
    chk("init_x4", ia3.rdata, 18'h0_0003);
    chk("init_x2", ib3.rdata, 18'h0_0001);
    idle();
    ia3.wen = 1; ia3.addr = 14'h000C; ia3.wdata = 18'h3_FFFF;
    step();
    idle();
    ib3.ren = 1; ib3.addr = 14'h000E;
    ia3.ren = 1; ia3.addr = 14'h0008;
    step();
    chk("x4_write_x2", ib3.rdata, 18'h0_0003);
    chk("x4_neighbor", ia3.rdata, 18'h0_0002);

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
